// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the instruction memory responder.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } imem_state_e;

  // Word-aligned and inside a store of the given number of words.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word store: synchronous write, registered read-enable port (read-before-write).
module imem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, fixed access latency, flush and preload port.
module imem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic        resp_err,
  input  logic        flush,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata,
  output logic        busy
);
  import riscv_pkg::*;

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  imem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        resp_err_q;
  logic        rdata_sel_q;
  logic        accept, enter_resp, rd_ok, rd_en, prog_ok;
  logic [31:0] rd_addr, rd_data;

  assign req_ready  = !flush && (state_q == IDLE || (state_q == RESP && resp_ready));
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_err   = resp_err_q;
  // Before any good read (and after reset) the array output is meaningless, so show NOP.
  assign resp_instr = rdata_sel_q ? rd_data : NOP_INSTR;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    enter_resp = 1'b0;
    rd_addr    = addr_q;
    if (flush) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    end else if (accept) begin
      addr_d = req_addr;
      cnt_d  = CNT_INIT;
      if (LATENCY == 1) begin
        // Single-cycle latency reads straight from the incoming address.
        state_d    = RESP;
        enter_resp = 1'b1;
        rd_addr    = req_addr;
      end else begin
        state_d = WAIT;
      end
    end else begin
      case (state_q)
        WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_ok   = addr_ok(rd_addr, DEPTH);
  assign rd_en   = enter_resp && rd_ok;
  assign prog_ok = prog_we && addr_ok(prog_addr, DEPTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      resp_err_q  <= 1'b0;
      rdata_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        resp_err_q  <= !rd_ok;
        rdata_sel_q <= rd_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (prog_ok),
    .waddr (prog_addr[AW+1:2]),
    .wdata (prog_wdata),
    .re    (rd_en),
    .raddr (rd_addr[AW+1:2]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=1 instance and a LATENCY=3 instance share stimulus.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        resp_ready = 1'b0;
  logic        flush = 1'b0;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_wdata = '0;

  logic        req_ready1, resp_valid1, resp_err1, busy1;
  logic [31:0] resp_instr1;
  logic        req_ready3, resp_valid3, resp_err3, busy3;
  logic [31:0] resp_instr3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_addr(req_addr), .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .resp_instr(resp_instr1), .resp_err(resp_err1), .flush(flush), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .busy(busy1)
  );

  imem_responder #(.DEPTH(16), .LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready3),
    .req_addr(req_addr), .resp_valid(resp_valid3), .resp_ready(resp_ready),
    .resp_instr(resp_instr3), .resp_err(resp_err3), .flush(flush), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .busy(busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (resp_valid1 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", resp_valid1); end
    total++; if (resp_instr1 !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", resp_instr1, NOP); end
    total++; if (resp_err1 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", resp_err1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    total++; if (req_ready1 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready1); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
    prog_write(32'h0, 32'h11);
    prog_write(32'h4, 32'h22);
    prog_write(32'h8, 32'h33);
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      req_addr = 32'(4 * (i + 1));
      if (i == 2) req_valid = 1'b0;
      total++; if (resp_valid1 !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, resp_valid1); end
      total++; if (resp_instr1 !== exp_d[i]) begin bad++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", i, resp_instr1, exp_d[i]); end
    end
    tick();
    total++; if (resp_valid1 !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b exp=0", resp_valid1); end
    tick(); tick();
  endtask

  task automatic test_single();
    prog_write(32'h0, 32'h00500093);
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0;
    total++; if (resp_valid1 !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", resp_valid1); end
    total++; if (resp_instr1 !== 32'h00500093) begin bad++; $display("FAIL single_instr got=%h exp=00500093", resp_instr1); end
    total++; if (resp_err1 !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", resp_err1); end
    tick();
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL single_idle busy=%b exp=0", busy1); end
    tick(); tick();
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (resp_valid1 !== 1'b1 || resp_instr1 !== 32'h22) begin
        bad++; $display("FAIL bp_hold[%0d] got valid=%b instr=%h exp valid=1 instr=00000022", i, resp_valid1, resp_instr1);
      end
      total++; if (req_ready1 !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, req_ready1); end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    total++; if (req_ready1 !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", req_ready1); end
    tick();
    total++; if (resp_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++; $display("FAIL bp_done got valid=%b busy=%b exp 0 0", resp_valid1, busy1);
    end
    tick(); tick();
  endtask

  task automatic fetch_err(input logic [31:0] a, input string nm);
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
    total++; if (resp_valid1 !== 1'b1 || resp_err1 !== 1'b1 || resp_instr1 !== NOP) begin
      bad++; $display("FAIL %s got valid=%b err=%b instr=%h exp 1 1 %h", nm, resp_valid1, resp_err1, resp_instr1, NOP);
    end
    resp_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic fetch_ok(input logic [31:0] a, input logic [31:0] e, input string nm);
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
    total++; if (resp_valid1 !== 1'b1 || resp_err1 !== 1'b0 || resp_instr1 !== e) begin
      bad++; $display("FAIL %s got valid=%b err=%b instr=%h exp 1 0 %h", nm, resp_valid1, resp_err1, resp_instr1, e);
    end
    resp_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_errors();
    fetch_err(32'h2, "err_misaligned");
    fetch_err(32'h1000, "err_range");
    prog_write(32'h6, 32'hDEADBEEF);
    prog_write(32'h1000, 32'h0BADF00D);
    fetch_ok(32'h4, 32'h22, "misaligned_write_ignored");
    fetch_ok(32'h0, 32'h00500093, "range_write_ignored");
  endtask

  task automatic test_latency3_flush();
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0;
    total++; if (resp_valid3 !== 1'b0 || busy3 !== 1'b1) begin
      bad++; $display("FAIL lat3_w1 got valid=%b busy=%b exp 0 1", resp_valid3, busy3);
    end
    tick();
    total++; if (resp_valid3 !== 1'b0) begin bad++; $display("FAIL lat3_w2 got=%b exp=0", resp_valid3); end
    tick();
    total++; if (resp_valid3 !== 1'b1 || resp_instr3 !== 32'h00500093) begin
      bad++; $display("FAIL lat3_resp got valid=%b instr=%h exp 1 00500093", resp_valid3, resp_instr3);
    end
    tick(); tick();
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    total++; if (req_ready3 !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", req_ready3); end
    tick();
    flush = 1'b0;
    total++; if (busy3 !== 1'b0 || resp_valid3 !== 1'b0) begin
      bad++; $display("FAIL flush_idle got busy=%b valid=%b exp 0 0", busy3, resp_valid3);
    end
    #1;
    total++; if (req_ready3 !== 1'b1) begin bad++; $display("FAIL flush_release_ready got=%b exp=1", req_ready3); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (resp_valid3 !== 1'b0) begin bad++; $display("FAIL flush_no_resp[%0d] got=%b exp=0", i, resp_valid3); end
    end
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    total++; if (resp_valid1 !== 1'b1 || resp_instr1 !== 32'h33) begin
      bad++; $display("FAIL rst_pre got valid=%b instr=%h exp 1 00000033", resp_valid1, resp_instr1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (resp_valid1 !== 1'b0 || resp_instr1 !== NOP || resp_err1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++; $display("FAIL rst_async got valid=%b instr=%h err=%b busy=%b exp 0 %h 0 0", resp_valid1, resp_instr1, resp_err1, busy1, NOP);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    fetch_ok(32'h0, 32'h00500093, "rst_mem_kept");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_backpressure();
    test_errors();
    test_latency3_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder serving fetch requests from the IF stage over a valid/ready request channel and a valid/ready response channel. It holds the word-addressed instruction store, a configurable access latency, and a program-load write port for boot/testbench preload. It supports one outstanding fetch. A flush input drops an in-flight fetch on a taken branch/jump redirect.

Parameters:
DEPTH, 1024, number of 32-bit instruction words; word index = addr[31:2]
LATENCY, 1, cycles from request acceptance edge to resp_valid assertion; legal range 1..15
NOP_INSTR, 32'h00000013, data returned on error responses and driven at reset

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  fetch request present
req_ready  output  1  responder can accept a request this cycle
req_addr  input  32  fetch byte address
resp_valid  output  1  response present
resp_ready  input  1  IF stage accepts response
resp_instr  output  32  fetched instruction
resp_err  output  1  misaligned or out-of-range fetch
flush  input  1  discard any in-flight fetch
prog_we  input  1  program-load write strobe
prog_addr  input  32  program-load byte address
prog_wdata  input  32  program-load data
busy  output  1  state != IDLE

Behaviour:
- One clock and reset: clk; reset_n is asynchronous, active-low.
- Reset values: state IDLE, resp_valid=0, resp_instr=NOP_INSTR, resp_err=0, wait counter=0, busy=0. Reset does not clear the memory array.
- States:
  - IDLE: req_ready=1 unless flush.
  - WAIT: counting down LATENCY-1 cycles.
  - RESP: resp_valid=1.
- Acceptance: a request is accepted when req_valid && req_ready at a clock edge. The responder latches req_addr and loads counter=LATENCY-1.
  - If LATENCY==1, it goes directly to RESP.
  - Otherwise it goes to WAIT and transitions to RESP when the counter reaches 0.
  - resp_valid rises exactly LATENCY cycles after the accepting edge.
- Read timing: array read occurs on the edge entering RESP. resp_instr and resp_err are registered there and held stable while resp_valid && !resp_ready.
- Errors: resp_err=1 and resp_instr=NOP_INSTR if addr[1:0]!=0 or addr[31:2]>=DEPTH. The array is not accessed.
- Response completion: on resp_valid && resp_ready, if req_valid is also asserted and flush is not, the next request is accepted in the same cycle. This gives 1 fetch/cycle at LATENCY=1. Otherwise the block returns to IDLE.
- req_ready = !flush && (state==IDLE || (state==RESP && resp_ready)).
- Flush:
  - In WAIT or RESP: next state IDLE, resp_valid=0 next cycle, response discarded, counter cleared.
  - In IDLE: no state effect; the request in that cycle is not accepted.
  - Flush has priority over resp_ready and req_valid.
- Program writes:
  - prog_we writes prog_wdata into word prog_addr[31:2] if aligned and in range; otherwise silently ignored.
  - Writes are allowed in any state.
  - Write and read to the same word on the same edge: the response returns the old data (read-before-write).
- Reset mid-operation: outputs return to reset values immediately (asynchronously). The pending fetch is lost.

Decomposition:
- riscv_pkg additions:
  - NOP_INSTR constant (32'h00000013).
  - imem_state_e typedef (IDLE, WAIT, RESP).
- Sub-module imem_array: DEPTH x 32 storage with synchronous write port and synchronous read-enable port (read-before-write). imem_responder holds the FSM, counter, range check and handshake logic.

Test Plan:
- Preload 0x00500093 at 0x0 via prog port, LATENCY=1; request 0x0 -> resp_valid one cycle after accept, resp_instr=0x00500093, resp_err=0.
- Preload 0x0/0x4/0x8 with 0x11,0x22,0x33; req_valid held, resp_ready=1 -> responses 0x11,0x22,0x33 on consecutive cycles, in order, no bubbles.
- Backpressure: resp_ready=0 for 3 cycles during RESP -> resp_valid=1 and resp_instr constant, req_ready=0; resp_ready=1 -> completion, return to IDLE.
- req_addr=0x2 -> resp_err=1, resp_instr=0x00000013; req_addr=4*DEPTH -> resp_err=1; prog write to 0x6 leaves memory unchanged.
- LATENCY=3; flush asserted in the second WAIT cycle -> resp_valid never rises, state IDLE next cycle, req_ready=1 after flush drops.
- reset_n pulled low mid-RESP -> resp_valid=0 and resp_instr=NOP_INSTR without waiting for a clock edge; after release, fetch of 0x0 returns the preloaded 0x00500093.
